// File: rtl/wdata_stream_writer_pkg.sv
// Shared types and default sizes for the C-matrix write-back engine.
package wdata_stream_writer_pkg;

    localparam int SYS_ARRAY_SIZE = 4;
    localparam int DATA_BITS      = 8;
    localparam int ROW_BITS       = SYS_ARRAY_SIZE * DATA_BITS;
    localparam int ROW_BYTES      = ROW_BITS / 8;
    localparam int ADDR_WIDTH     = 16;
    localparam int ROW_CNT_W      = $clog2(SYS_ARRAY_SIZE + 1);

    typedef logic signed [DATA_BITS-1:0] data_t;
    typedef logic [ROW_BITS-1:0]         row_t;
    typedef logic [ROW_CNT_W-1:0]        row_cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } wsw_state_t;

endpackage

// File: rtl/wdata_stream_writer_fifo.sv
// Synchronous row FIFO; a push into a full FIFO is taken when a pop happens in the same cycle.
module wdata_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/wdata_stream_writer.sv
// Streams systolic-array result rows into C memory at base + i*stride, buffering through a row FIFO.
// Optional WDATA_STALL_CNT_EN adds stall_cnt_o, counting request cycles refused by the memory.
module wdata_stream_writer
    import wdata_stream_writer_pkg::*;
#(
    parameter int NUM_ROWS   = SYS_ARRAY_SIZE,
    parameter int ADDR_W     = ADDR_WIDTH,
    parameter int ROW_W      = ROW_BITS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    output logic                          start_ready_o,
    input  logic [ADDR_W-1:0]             addr_c_i,
    input  logic [ADDR_W-1:0]             stride_i,
    input  logic [$clog2(NUM_ROWS+1)-1:0] nrows_i,
    input  logic                          row_valid_i,
    input  logic [ROW_W-1:0]              row_i,
    output logic                          en_c_o,
    input  logic                          gnt_c_i,
    output logic [ADDR_W-1:0]             addr_c_o,
    output logic [ROW_W-1:0]              wdata_c_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          overflow_o
`ifdef WDATA_STALL_CNT_EN
    ,
    output logic [31:0]                   stall_cnt_o
`endif
);

    localparam int                CNT_W    = $clog2(NUM_ROWS + 1);
    localparam logic [CNT_W-1:0]  MAX_ROWS = CNT_W'(NUM_ROWS);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(ROW_W / 8);

    function automatic logic [CNT_W-1:0] eff_rows(input logic [CNT_W-1:0] n);
        return (n == '0 || n > MAX_ROWS) ? MAX_ROWS : n;
    endfunction

    wsw_state_t        state;
    wsw_state_t        state_nxt;
    logic [CNT_W-1:0]  job_rows;
    logic [CNT_W-1:0]  rcv_cnt;
    logic [CNT_W-1:0]  wr_cnt;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  wr_nxt;
    logic [CNT_W-1:0]  drop_nxt;
    logic [ADDR_W-1:0] stride_r;
    logic [ADDR_W-1:0] cur_addr;
    logic              ovf_r;
    logic              accept_start;
    logic              in_run;
    logic              push_req;
    logic              drop_now;
    logic              push;
    logic              pop;
    logic              finish;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ROW_W-1:0]  fifo_head;

    assign accept_start = (state == IDLE) && start_i;
    assign in_run       = (state == RUN);
    assign en_c_o       = in_run && !fifo_empty;
    assign pop          = en_c_o && gnt_c_i;
    assign push_req     = in_run && row_valid_i && (rcv_cnt < job_rows);
    assign drop_now     = push_req && fifo_full && !pop;
    assign push         = push_req && !drop_now;
    assign wr_nxt       = wr_cnt + CNT_W'(pop);
    assign drop_nxt     = drop_cnt + CNT_W'(drop_now);
    // A job ends once every expected row is either written or known to be lost.
    assign finish       = in_run && (({1'b0, wr_nxt} + {1'b0, drop_nxt}) == {1'b0, job_rows});

    assign start_ready_o = (state == IDLE);
    assign busy_o        = (state != IDLE);
    assign done_o        = (state == DONE);
    assign overflow_o    = ovf_r;
    assign addr_c_o      = cur_addr;
    assign wdata_c_o     = en_c_o ? fifo_head : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = RUN;
            RUN:     if (finish)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            rcv_cnt  <= '0;
            wr_cnt   <= '0;
            drop_cnt <= '0;
            ovf_r    <= 1'b0;
            cur_addr <= '0;
        end else begin
            state <= state_nxt;
            if (accept_start) begin
                rcv_cnt  <= '0;
                wr_cnt   <= '0;
                drop_cnt <= '0;
                ovf_r    <= 1'b0;
                cur_addr <= addr_c_i;
            end else if (in_run) begin
                if (push_req) rcv_cnt <= rcv_cnt + CNT_W'(1);
                wr_cnt   <= wr_nxt;
                drop_cnt <= drop_nxt;
                if (drop_now) ovf_r <= 1'b1;
                if (pop) cur_addr <= cur_addr + stride_r;
            end
        end
    end

    // Job configuration is only consulted in RUN, so it is loaded on start and never reset.
    always_ff @(posedge clk_i) begin
        if (accept_start) begin
            stride_r <= (stride_i == '0) ? ROW_STEP : stride_i;
            job_rows <= eff_rows(nrows_i);
        end
    end

    wdata_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (accept_start),
        .push_i  (push),
        .data_i  (row_i),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef WDATA_STALL_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || accept_start) begin
            stall_cnt <= '0;
        end else if (en_c_o && !gnt_c_i && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
`endif

endmodule

// File: tb/tb_wdata_stream_writer.sv
// Bench for wdata_stream_writer: directed scenarios and randomized jobs checked against
// a queue-based behavioural model of the write-back rules.
module tb_wdata_stream_writer;

    localparam int FD = 2;
    localparam int NR = 4;
    localparam int RB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i, start_i, start_ready_o, row_valid_i, en_c_o, gnt_c_i;
    logic        busy_o, done_o, overflow_o;
    logic [15:0] addr_c_i, stride_i, addr_c_o;
    logic [2:0]  nrows_i;
    logic [31:0] row_i, wdata_c_o;
`ifdef WDATA_STALL_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    wdata_stream_writer #(
        .FIFO_DEPTH (FD)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .start_ready_o (start_ready_o),
        .addr_c_i      (addr_c_i),
        .stride_i      (stride_i),
        .nrows_i       (nrows_i),
        .row_valid_i   (row_valid_i),
        .row_i         (row_i),
        .en_c_o        (en_c_o),
        .gnt_c_i       (gnt_c_i),
        .addr_c_o      (addr_c_o),
        .wdata_c_o     (wdata_c_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .overflow_o    (overflow_o)
`ifdef WDATA_STALL_CNT_EN
        ,
        .stall_cnt_o   (stall_cnt_o)
`endif
    );

    // Behavioural model: mode 0 idle, 1 running, 2 finishing.
    int unsigned m_mode, m_base, m_stride, m_n, m_rcv, m_wr, m_drop;
    logic        m_ovf;
    logic [31:0] m_stall;
    logic [31:0] q[$];

    int          n_chk, n_pass, cyc, t0, done_cyc;
    logic [15:0] obs_a[$];
    logic [31:0] obs_d[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_tick(input logic st, input logic rv, input logic [31:0] row,
                              input logic gnt, input logic r);
        bit popped;
        if (r) begin
            m_mode = 0; q.delete(); m_ovf = 1'b0; m_stall = '0;
            return;
        end
        case (m_mode)
            0: if (st) begin
                m_base   = addr_c_i;
                m_stride = (stride_i == 16'h0) ? RB : stride_i;
                m_n      = (nrows_i == 3'd0 || nrows_i > NR) ? NR : nrows_i;
                q.delete();
                m_rcv = 0; m_wr = 0; m_drop = 0; m_ovf = 1'b0; m_stall = '0;
                m_mode = 1;
            end
            1: begin
                popped = (q.size() > 0) && gnt;
                if (q.size() > 0 && !gnt && m_stall != 32'hFFFF_FFFF) m_stall++;
                if (popped) begin
                    void'(q.pop_front());
                    m_wr++;
                end
                if (rv && m_rcv < m_n) begin
                    m_rcv++;
                    if (q.size() < FD) q.push_back(row);
                    else begin
                        m_drop++;
                        m_ovf = 1'b1;
                    end
                end
                if (m_wr + m_drop == m_n) m_mode = 2;
            end
            default: m_mode = 0;
        endcase
    endtask

    task automatic step(input logic st, input logic rv, input logic [31:0] row,
                        input logic gnt, input logic r);
        logic exp_en;
        start_i = st; row_valid_i = rv; row_i = row; gnt_c_i = gnt; rst_i = r;
        exp_en = (m_mode == 1) && (q.size() > 0);
        chk("en_c_o", en_c_o, exp_en);
        if (exp_en) begin
            chk("addr_c_o", addr_c_o, 16'(m_base + m_wr * m_stride));
            chk("wdata_c_o", wdata_c_o, q[0]);
        end
        chk("start_ready_o", start_ready_o, m_mode == 0);
        chk("busy_o", busy_o, m_mode != 0);
        chk("done_o", done_o, m_mode == 2);
        chk("overflow_o", overflow_o, m_ovf);
`ifdef WDATA_STALL_CNT_EN
        chk("stall_cnt_o", stall_cnt_o, m_stall);
`endif
        if (en_c_o && gnt) begin
            obs_a.push_back(addr_c_o);
            obs_d.push_back(wdata_c_o);
        end
        if (done_o) done_cyc = cyc;
        model_tick(st, rv, row, gnt, r);
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic start_job(input logic [15:0] base, input logic [15:0] stride, input logic [2:0] nr);
        addr_c_i = base; stride_i = stride; nrows_i = nr;
        obs_a.delete(); obs_d.delete();
        done_cyc = -1;
        t0 = cyc;
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic drain(input int max_cycles);
        for (int k = 0; k < max_cycles && m_mode != 0; k++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("job_returned_idle", start_ready_o, 1'b1);
    endtask

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0; done_cyc = -1; t0 = 0;
        m_mode = 0; m_ovf = 1'b0; m_stall = '0;
        m_base = 0; m_stride = RB; m_n = NR; m_rcv = 0; m_wr = 0; m_drop = 0;
        rst_i = 1'b1; start_i = 1'b0; row_valid_i = 1'b0; row_i = '0; gnt_c_i = 1'b0;
        addr_c_i = '0; stride_i = '0; nrows_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        chk("rst_en", en_c_o, 1'b0);
        chk("rst_addr", addr_c_o, 16'h0);
        chk("rst_wdata", wdata_c_o, 32'h0);
        chk("rst_ready", start_ready_o, 1'b1);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_ovf", overflow_o, 1'b0);
`ifdef WDATA_STALL_CNT_EN
        chk("rst_stall", stall_cnt_o, 32'h0);
`endif
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Default stride, four back-to-back rows, memory always granting
        start_job(16'h0100, 16'h0000, 3'd4);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 32'hA000_0000 + k, 1'b1, 1'b0);
        drain(10);
        chk("t1_nwr", obs_a.size(), 4);
        for (int i = 0; i < obs_a.size(); i++) begin
            chk("t1_addr", obs_a[i], 16'h0100 + 16'(i * RB));
            chk("t1_data", obs_d[i], 32'hA000_0000 + i);
        end
        chk("t1_done_cycle", done_cyc - t0, 6);
        chk("t1_ovf", overflow_o, 1'b0);

        // Stalled memory: request must hold; third row lands on a full FIFO while popping
        start_job(16'h0200, 16'h0040, 3'd3);
        step(1'b0, 1'b1, 32'hB0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'hB1, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'hB2, 1'b1, 1'b0);
        drain(10);
        chk("t2_nwr", obs_a.size(), 3);
        for (int i = 0; i < obs_a.size(); i++) begin
            chk("t2_addr", obs_a[i], 16'h0200 + 16'(i * 16'h40));
            chk("t2_data", obs_d[i], 32'hB0 + i);
        end
        chk("t2_ovf", overflow_o, 1'b0);
`ifdef WDATA_STALL_CNT_EN
        chk("t2_stall_cnt", stall_cnt_o, 32'd5);
`endif

        // Overflow: no grants while four rows stream into a two-entry FIFO
        start_job(16'h0300, 16'h0000, 3'd4);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 32'hC0 + k, 1'b0, 1'b0);
        drain(10);
        chk("t3_nwr", obs_a.size(), 2);
        for (int i = 0; i < obs_a.size(); i++) chk("t3_data", obs_d[i], 32'hC0 + i);
        chk("t3_ovf", overflow_o, 1'b1);
        chk("t3_done_cycle", done_cyc - t0, 7);

        // Address wraps past the top of the address space
        start_job(16'hFFFC, 16'h0000, 3'd2);
        for (int k = 0; k < 2; k++) step(1'b0, 1'b1, 32'hF0 + k, 1'b1, 1'b0);
        drain(10);
        chk("t4_nwr", obs_a.size(), 2);
        if (obs_a.size() == 2) begin
            chk("t4_addr0", obs_a[0], 16'hFFFC);
            chk("t4_addr1", obs_a[1], 16'h0000);
        end

        // nrows 0 selects the maximum; surplus rows are ignored without overflow
        start_job(16'h0500, 16'h0000, 3'd0);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 32'hD0 + k, 1'b1, 1'b0);
        drain(10);
        step(1'b0, 1'b1, 32'hDEAD, 1'b1, 1'b0);
        chk("t5_nwr", obs_a.size(), NR);
        chk("t5_last_data", obs_d[obs_a.size()-1], 32'hD3);
        chk("t5_ovf", overflow_o, 1'b0);

        // Reset in the middle of a job, then a clean job
        start_job(16'h0600, 16'h0000, 3'd4);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 32'hE0 + k, 1'b1, 1'b0);
        chk("t6_writes_before_rst", obs_a.size(), 2);
        step(1'b0, 1'b1, 32'hE3, 1'b1, 1'b1);
        chk("t6_en_after_rst", en_c_o, 1'b0);
        chk("t6_busy_after_rst", busy_o, 1'b0);
        chk("t6_ready_after_rst", start_ready_o, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        start_job(16'h0700, 16'h0000, 3'd4);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 32'h70 + k, 1'b1, 1'b0);
        drain(10);
        chk("t6_new_nwr", obs_a.size(), 4);
        chk("t6_new_done_cycle", done_cyc - t0, 6);

        // Randomized jobs: addresses, strides, counts, row gaps, grant gaps, stray starts
        for (int j = 0; j < 40; j++) begin
            int vp, gp;
            vp = $urandom_range(100, 30);
            gp = $urandom_range(100, 20);
            start_job(16'($urandom), ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom_range(255)),
                      3'($urandom));
            for (int k = 0; k < 300 && m_mode != 0; k++)
                step($urandom_range(7) == 0, $urandom_range(99) < vp, $urandom,
                     $urandom_range(99) < gp, 1'b0);
            chk("rnd_job_idle", start_ready_o, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wdata_stream_writer.md
# wdata_stream_writer

Parametrised write-back engine that streams result rows from the systolic array into C memory at a runtime base address and stride. Accepts a per-job row count, absorbs memory back-pressure with an internal row FIFO, and flags rows lost to overflow. Sits between the systolic array output and the C memory port, and is started by the rdata handler.

## Interface
- `NUM_ROWS`, default `SYS_ARRAY_SIZE`: maximum rows per job.
- `ADDR_W`, default `ADDR_WIDTH`: byte-address width.
- `ROW_W`, default `ROW_BITS`: bits per row (`SYS_ARRAY_SIZE` × data_t).
- `FIFO_DEPTH`, default 4: row buffer entries, power of two, ≥ 2.
- `clk_i` in 1: clock; single clock domain.
- `rst_i` in 1: synchronous, active-high reset.
- `start_i` in 1: job request, accepted only when `start_ready_o`=1.
- `start_ready_o` out 1: high in IDLE.
- `addr_c_i` in ADDR_W: base byte address of row 0, sampled on start.
- `stride_i` in ADDR_W: byte distance between rows; 0 means `ROW_BYTES`.
- `nrows_i` in $clog2(NUM_ROWS+1): rows in job; 0 or >NUM_ROWS means NUM_ROWS.
- `row_valid_i` in 1: result row present on `row_i` (array cannot stall).
- `row_i` in ROW_W: result row.
- `en_c_o` out 1: memory write request.
- `gnt_c_i` in 1: memory accepts the request this cycle.
- `addr_c_o` out ADDR_W: write byte address.
- `wdata_c_o` out ROW_W: write data.
- `busy_o` out 1: state ≠ IDLE.
- `done_o` out 1: one-cycle pulse, last row written.
- `overflow_o` out 1: sticky, ≥1 row dropped in current/last job.

## Operation
- FSM states IDLE → RUN → DONE → IDLE.
- IDLE: `start_i`=1 latches base, effective stride, effective row count; clears counters, FIFO, `overflow_o`; goes to RUN.
- RUN: `row_valid_i`=1 pushes while `rcv_cnt` < row count; `rcv_cnt`++. Rows beyond count, and rows in IDLE/DONE, are ignored (no push, no flag).
- Push with FIFO full and no pop in the same cycle: row dropped, `rcv_cnt` still increments, `overflow_o` set. Push with full FIFO and simultaneous pop: accepted.
- `en_c_o` = RUN and FIFO non-empty; `wdata_c_o` = FIFO head; `addr_c_o` = current address.
- `en_c_o`&`gnt_c_i`: pop, address += stride (modulo 2^ADDR_W, wraps silently), `wr_cnt`++.
- RUN exits when `wr_cnt` + dropped rows = row count; → DONE. DONE: `done_o`=1 for one cycle, `start_i` ignored, → IDLE.
- Request is held stable (addr/data/en) until granted; never withdrawn.
- Reset (any state): state IDLE, FIFO empty, counters 0, all outputs 0 except `start_ready_o`=1.

## Timing
- Start at cycle 0 → RUN from cycle 1; rows accepted from cycle 1.
- FIFO registered: row pushed in cycle t is requested no earlier than t+1.
- `gnt_c_i` tied 1, rows on cycles 1..N: writes on cycles 2..N+1, `done_o` at cycle N+2, `start_ready_o` at N+3.
- Back-to-back jobs: start accepted the cycle after DONE.
- Outputs `en_c_o`, `addr_c_o`, `wdata_c_o` derive from registers only (no combinational path from `gnt_c_i`).

## Configuration
- `WDATA_STALL_CNT_EN` defined: adds output `stall_cnt_o` [31:0], counting cycles with `en_c_o`=1 and `gnt_c_i`=0 since the last accepted start; saturates at all-ones; reset 0.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Shared package: `row_t` (ROW_W vector), `wsw_state_t` enum {IDLE, RUN, DONE}, `ROW_BYTES`, row-count type.
- One sub-module: `wdata_fifo`, synchronous FIFO (WIDTH, DEPTH), push/pop/full/empty, simultaneous push+pop when full allowed.

## Test plan
- Base 0x100, stride 0, nrows 4, rows on 4 consecutive cycles, gnt=1 → writes at 0x100, +ROW_BYTES ×3 in order; `done_o` at cycle 6; overflow 0.
- Stride 0x40, nrows 3, gnt low for 5 cycles after first request → addr/data held stable while stalled; writes 0x..00/40/80; stall_cnt_o=5 (macro on).
- FIFO_DEPTH 2, nrows 4, rows back-to-back, gnt=0 throughout rows → rows 2,3 dropped, `overflow_o`=1, only rows 0,1 written, `done_o` still pulses.
- Base 2^ADDR_W−ROW_BYTES, nrows 2 → second write at address 0.
- nrows 0 → NUM_ROWS rows written; extra `row_valid_i` after count ignored, no overflow.
- Reset asserted mid-job after 2 of 4 writes → next cycle en_c_o=0, busy_o=0, start_ready_o=1; new job completes normally.
